// File: rtl/video_fetch_buf.sv
// Fetch-assembly stage: steers 16-bit DRAM video bytes into a 32-bit accumulator
// and commits {mask, word} into a small FIFO drained by the renderer.
module video_fetch_buf #(
   parameter int DEPTH = 2,
   parameter int PTR_W = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             video_strb,
   input  logic [15:0]      video_data,
   input  logic [3:0]       fetch_sel,
   input  logic [1:0]       fetch_bsl,
   input  logic             fetch_stb,
   input  logic             line_start_s,
   input  logic             fetch_rd,
   input  logic             clr_err,
   output logic [31:0]      fetch_data,
   output logic [3:0]       fetch_mask,
   output logic             fetch_valid,
   output logic [PTR_W:0]   fifo_level,
   output logic             ovf,
   output logic             udf
);

   localparam logic [PTR_W:0] LVL_FULL = (PTR_W+1)'(DEPTH);

   logic [31:0]                acc_q, acc_d, acc_nx;
   logic [3:0]                 got_q, got_d, got_nx;
   logic [DEPTH-1:0][35:0]     mem_q;
   logic [PTR_W-1:0]           wp_q, wp_d, rp_q, rp_d;
   logic [PTR_W:0]             lvl_q, lvl_d;
   logic                       ovf_q, ovf_d, udf_q, udf_d;
   logic [7:0]                 lane_e, lane_o;
   logic                       empty, full, pop_ok, push_ok, wr_en;
   logic [35:0]                head;

   assign lane_e = fetch_bsl[0] ? video_data[15:8] : video_data[7:0];
   assign lane_o = fetch_bsl[1] ? video_data[15:8] : video_data[7:0];

   // Bytes written this cycle are bypassed into the word pushed this cycle.
   always_comb begin
      acc_nx = acc_q;
      got_nx = got_q;
      for (int i = 0; i < 4; i++) begin
         if (video_strb && fetch_sel[i]) begin
            acc_nx[i*8 +: 8] = i[0] ? lane_o : lane_e;
            got_nx[i]        = 1'b1;
         end
      end
   end

   assign empty   = (lvl_q == '0);
   assign full    = (lvl_q == LVL_FULL);
   assign pop_ok  = fetch_rd && !empty;
   assign push_ok = fetch_stb && (!full || pop_ok);

   always_comb begin
      acc_d = acc_nx;
      got_d = fetch_stb ? 4'b0000 : got_nx;
      wp_d  = wp_q;
      rp_d  = rp_q;
      lvl_d = lvl_q;
      wr_en = 1'b0;
      ovf_d = (fetch_stb && full && !pop_ok) || (ovf_q && !clr_err);
      udf_d = (fetch_rd && empty) || (udf_q && !clr_err);
      if (line_start_s) begin
         acc_d = '0;
         got_d = '0;
         wp_d  = '0;
         rp_d  = '0;
         lvl_d = '0;
         ovf_d = ovf_q && !clr_err;
         udf_d = udf_q && !clr_err;
      end else begin
         if (push_ok) begin
            wr_en = 1'b1;
            wp_d  = wp_q + PTR_W'(1);
         end
         if (pop_ok) rp_d = rp_q + PTR_W'(1);
         lvl_d = lvl_q + {{PTR_W{1'b0}}, push_ok} - {{PTR_W{1'b0}}, pop_ok};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         got_q <= '0;
         mem_q <= '0;
         wp_q  <= '0;
         rp_q  <= '0;
         lvl_q <= '0;
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         got_q <= got_d;
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         lvl_q <= lvl_d;
         ovf_q <= ovf_d;
         udf_q <= udf_d;
         if (wr_en) mem_q[wp_q] <= {got_nx, acc_nx};
      end
   end

   // Head comes straight from storage flops; gated to zero when empty.
   assign head        = mem_q[rp_q];
   assign fetch_valid = !empty;
   assign fetch_data  = empty ? 32'h0 : head[31:0];
   assign fetch_mask  = empty ? 4'h0  : head[35:32];
   assign fifo_level  = lvl_q;
   assign ovf         = ovf_q;
   assign udf         = udf_q;

endmodule

// File: tb/tb_video_fetch_buf.sv
// Directed bench for video_fetch_buf: expected {mask,data} words are queued at
// issue time and checked by an independent monitor on every renderer pop.
module tb_video_fetch_buf;

   logic        clk, rst_n;
   logic        video_strb, fetch_stb, line_start_s, fetch_rd, clr_err;
   logic [15:0] video_data;
   logic [3:0]  fetch_sel;
   logic [1:0]  fetch_bsl;
   logic [31:0] fetch_data;
   logic [3:0]  fetch_mask;
   logic        fetch_valid, ovf, udf;
   logic [1:0]  fifo_level;

   int n_cmp = 0;
   int n_err = 0;
   logic [35:0] sb[$];

   video_fetch_buf #(.DEPTH(2), .PTR_W(1)) dut (
      .clk(clk), .rst_n(rst_n), .video_strb(video_strb), .video_data(video_data),
      .fetch_sel(fetch_sel), .fetch_bsl(fetch_bsl), .fetch_stb(fetch_stb),
      .line_start_s(line_start_s), .fetch_rd(fetch_rd), .clr_err(clr_err),
      .fetch_data(fetch_data), .fetch_mask(fetch_mask), .fetch_valid(fetch_valid),
      .fifo_level(fifo_level), .ovf(ovf), .udf(udf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every accepted pop must present the oldest expected word.
   always @(negedge clk) begin
      if (rst_n && fetch_rd && fetch_valid) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL pop_unexpected: got %h expected no word", {fetch_mask, fetch_data});
         end else begin
            chk("pop_head", {fetch_mask, fetch_data}, sb.pop_front());
         end
      end
   end

   task automatic cyc(input logic s, input logic [3:0] sel, input logic [1:0] bsl,
                      input logic [15:0] d, input logic stb, input logic ls,
                      input logic rd, input logic clr);
      video_strb = s; fetch_sel = sel; fetch_bsl = bsl; video_data = d;
      fetch_stb = stb; line_start_s = ls; fetch_rd = rd; clr_err = clr;
      @(posedge clk); #1;
      video_strb = 0; fetch_sel = 0; fetch_bsl = 0; video_data = 0;
      fetch_stb = 0; line_start_s = 0; fetch_rd = 0; clr_err = 0;
   endtask

   task automatic chk_st(input string name, input int lvl, input logic o, input logic u);
      chk({name, "_level"}, 36'(fifo_level), 36'(lvl));
      chk({name, "_ovf"}, 36'(ovf), 36'(o));
      chk({name, "_udf"}, 36'(udf), 36'(u));
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 0;
      video_strb = 0; fetch_sel = 0; fetch_bsl = 0; video_data = 0;
      fetch_stb = 0; line_start_s = 0; fetch_rd = 0; clr_err = 0;
      #3;
      chk("rst_out", {fetch_mask, fetch_data}, 36'h0);
      chk("rst_valid", 36'(fetch_valid), 36'h0);
      chk_st("rst", 0, 0, 0);
      #9 rst_n = 1;
      @(posedge clk); #1;

      // Text-mode gather then graphics overwrite of bytes 0/1
      cyc(1, 4'b0011, 2'b10, 16'h4241, 0, 0, 0, 0);
      cyc(1, 4'b1100, 2'b10, 16'h0705, 0, 0, 0, 0);
      cyc(1, 4'b0001, 2'b00, 16'h1234, 0, 0, 0, 0);
      cyc(1, 4'b0010, 2'b11, 16'hAB99, 0, 0, 0, 0);
      sb.push_back({4'b1111, 32'h0705AB34});
      cyc(0, 0, 0, 0, 1, 0, 0, 0);
      chk("gather_valid", 36'(fetch_valid), 36'h1);
      chk("gather_head", {fetch_mask, fetch_data}, {4'b1111, 32'h0705AB34});
      cyc(0, 0, 0, 0, 0, 0, 1, 0);
      chk("gather_empty_data", {fetch_mask, fetch_data}, 36'h0);

      // Same-cycle strobe + commit, then a commit with nothing gathered
      sb.push_back({4'b1111, 32'hBEEFBEEF});
      cyc(1, 4'b1111, 2'b10, 16'hBEEF, 1, 0, 0, 0);
      sb.push_back({4'b0000, 32'hBEEFBEEF});
      cyc(0, 0, 0, 0, 1, 0, 0, 0);
      chk_st("bypass", 2, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 1, 0);

      // Overflow: third push dropped, head stays the first
      sb.push_back({4'b0001, 32'hBEEFBE11});
      cyc(1, 4'b0001, 2'b00, 16'h0011, 1, 0, 0, 0);
      sb.push_back({4'b0010, 32'hBEEF2211});
      cyc(1, 4'b0010, 2'b00, 16'h0022, 1, 0, 0, 0);
      cyc(1, 4'b0100, 2'b00, 16'h0033, 1, 0, 0, 0);
      chk_st("ovf", 2, 1, 0);
      chk("ovf_head", {fetch_mask, fetch_data}, {4'b0001, 32'hBEEFBE11});
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      chk_st("ovf_clr", 2, 0, 0);
      sb.push_back({4'b0000, 32'hBE332211});
      cyc(0, 0, 0, 0, 1, 0, 1, 0);
      chk_st("full_pushpop", 2, 0, 0);
      cyc(0, 0, 0, 0, 1, 0, 0, 1);
      chk_st("ovf_setwins", 2, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 1, 1);
      cyc(0, 0, 0, 0, 0, 0, 1, 0);
      chk_st("drained", 0, 0, 0);

      // Underrun with simultaneous push: push still stored
      sb.push_back({4'b0000, 32'hBE332211});
      cyc(0, 0, 0, 0, 1, 0, 1, 0);
      chk_st("udf", 1, 0, 1);
      chk("udf_head", {fetch_mask, fetch_data}, {4'b0000, 32'hBE332211});
      cyc(0, 0, 0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      chk_st("udf_clr", 0, 0, 0);

      // Flush at level 2 discards push/pop/accumulate, keeps flags
      cyc(0, 0, 0, 0, 0, 0, 1, 0);
      sb.push_back({4'b0000, 32'hBE332211});
      cyc(0, 0, 0, 0, 1, 0, 0, 0);
      sb.push_back({4'b0000, 32'hBE332211});
      cyc(0, 0, 0, 0, 1, 0, 0, 0);
      chk_st("pre_flush", 2, 0, 1);
      cyc(1, 4'b1111, 2'b00, 16'hFFFF, 1, 1, 1, 0);
      sb.delete();
      chk_st("flush", 0, 0, 1);
      chk("flush_valid", 36'(fetch_valid), 36'h0);
      chk("flush_data", {fetch_mask, fetch_data}, 36'h0);
      sb.push_back({4'b0001, 32'h00000055});
      cyc(1, 4'b0001, 2'b00, 16'h0055, 1, 0, 0, 1);
      chk("acc_cleared", {fetch_mask, fetch_data}, {4'b0001, 32'h00000055});
      cyc(0, 0, 0, 0, 0, 0, 1, 0);

      // Async reset mid-line with level 1 and ovf set
      sb.push_back({4'b0000, 32'h00000055});
      cyc(0, 0, 0, 0, 1, 0, 0, 0);
      sb.push_back({4'b0000, 32'h00000055});
      cyc(0, 0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 1, 0);
      chk_st("pre_rst", 1, 1, 0);
      #2 rst_n = 0;
      #1;
      chk("arst_out", {fetch_mask, fetch_data}, 36'h0);
      chk("arst_valid", 36'(fetch_valid), 36'h0);
      chk_st("arst", 0, 0, 0);
      sb.delete();
      #1 rst_n = 1;
      @(posedge clk); #1;
      sb.push_back({4'b1000, 32'hC3000000});
      cyc(1, 4'b1000, 2'b11, 16'hC300, 1, 0, 0, 0);
      chk_st("post_rst", 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 1, 0);
      chk("sb_drained", 36'(sb.size()), 36'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
